hs_ram_arbiter: RTL and testbench

Shares the game CPU's work-RAM port between the CPU and the hiscore save/restore engine. When the hiscore engine requests access, the block does the following in order:
- waits for vertical blank;
- raises a pause request toward the pause system;
- waits for the CPU to report paused, then lets the bus settle;
- hands the RAM port to the hiscore engine for single-byte accesses.

On release it returns the port to the CPU and drops the pause request. It sits between the hiscore module, the pause system and the Gyruss core RAM mux, all on the 49.152 MHz system clock.

---
 rtl/hs_pkg.sv | 33 +++
 rtl/hs_ram_mux.sv | 43 ++++
 rtl/hs_ram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// ============================================================================
// Package  : hs_pkg
// Brief    : Shared types and defaults for the hiscore work-RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hs_pkg;

    localparam int unsigned C_HS_AW      = 11;
    localparam int unsigned C_HS_DW      = 8;
    localparam int unsigned C_HS_SETTLE  = 4;
    localparam int unsigned C_HS_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VBL = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_GRANT    = 3'd4,
        ST_RELEASE  = 3'd5
    } hs_arb_state_t;

    // The shared counter also times SETTLE (up to 15), so never go below 4 bits.
    function automatic int unsigned hs_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs_ram_mux.sv
// ============================================================================
// Module   : hs_ram_mux
// Brief    : Combinational CPU / hiscore select onto the work-RAM port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_ram_mux
    import hs_pkg::*;
#(
    parameter int unsigned AW = C_HS_AW,
    parameter int unsigned DW = C_HS_DW
) (
    input  logic          sel_hs_i,
    input  logic          cpu_we_block_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] hs_addr_i,
    input  logic [DW-1:0] hs_wdata_i,
    input  logic          hs_we_i,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic          ram_we_o
);

    always_comb begin
        if (sel_hs_i) begin
            ram_addr_o  = hs_addr_i;
            ram_wdata_o = hs_wdata_i;
            ram_we_o    = hs_we_i;
        end else begin
            ram_addr_o  = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
            // A CPU still finishing its last bus cycle must not land a write
            // while the hiscore engine is about to own, or owns, the RAM.
            ram_we_o    = cpu_we_i & ~cpu_we_block_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hs_ram_arbiter.sv
// ============================================================================
// Module   : hs_ram_arbiter
// Brief    : Pauses the CPU at vblank and lends its work-RAM port to the
//            hiscore save/restore engine for single-byte accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_ram_arbiter
    import hs_pkg::*;
#(
    parameter int unsigned AW       = C_HS_AW,
    parameter int unsigned DW       = C_HS_DW,
    parameter int unsigned SETTLE   = C_HS_SETTLE,
    parameter int unsigned TIMEOUT  = C_HS_TIMEOUT,
    parameter int unsigned VBL_SYNC = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    input  logic          hs_strobe,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_ack,
    output logic          hs_grant,
    output logic          hs_abort,
    output logic          pause_req,
    input  logic          cpu_paused,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned CW = hs_cnt_width(TIMEOUT);

    hs_arb_state_t state_q;
    hs_arb_state_t state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          vbl_q;
    logic          pause_req_q;
    logic          hs_grant_q;
    logic          hs_ack_q;
    logic          ack_rd_q;
    logic          hs_abort_q;
    logic [DW-1:0] rdata_q;

    logic          w_vbl_rise;
    logic          w_timeout;
    logic          w_settle_done;
    logic          w_abort;
    logic          w_strobe;
    logic          w_hs_we;
    logic          w_pause_d;
    logic          w_cpu_we_block;

    assign w_vbl_rise    = vblank & ~vbl_q;
    assign w_timeout     = (cnt_q == CW'(TIMEOUT - 1));
    assign w_settle_done = (cnt_q == CW'(SETTLE - 1));

    // A strobe coinciding with the release request is dropped entirely.
    assign w_strobe = hs_grant_q & hs_req & hs_strobe;
    assign w_hs_we  = w_strobe & hs_we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_req) begin
                    state_d = (VBL_SYNC != 0) ? ST_WAIT_VBL : ST_PAUSE;
                end
            end
            ST_WAIT_VBL: begin
                if (!hs_req) begin
                    state_d = ST_IDLE;
                end else if (w_vbl_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!hs_req) begin
                    state_d = ST_RELEASE;
                end else if (cpu_paused) begin
                    state_d = ST_SETTLE;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!hs_req) begin
                    state_d = ST_RELEASE;
                end else if (!cpu_paused) begin
                    state_d = ST_PAUSE;
                end else if (w_settle_done) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!hs_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_abort = (state_q == ST_PAUSE) & hs_req & ~cpu_paused & w_timeout;

    // Every state change restarts the shared counter; it saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (((state_q == ST_PAUSE) || (state_q == ST_SETTLE)) &&
                     (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign w_pause_d = (state_d == ST_PAUSE)  || (state_d == ST_SETTLE) ||
                       (state_d == ST_GRANT)  || (state_d == ST_RELEASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vbl_q       <= 1'b0;
            pause_req_q <= 1'b0;
            hs_grant_q  <= 1'b0;
            hs_ack_q    <= 1'b0;
            ack_rd_q    <= 1'b0;
            hs_abort_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vbl_q       <= vblank;
            // On abort the pause request lingers for the abort cycle itself.
            pause_req_q <= w_pause_d | w_abort;
            hs_grant_q  <= (state_d == ST_GRANT);
            hs_ack_q    <= w_strobe;
            ack_rd_q    <= w_strobe & ~hs_we;
            hs_abort_q  <= w_abort;
            if (hs_ack_q && ack_rd_q) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    // Read data is forwarded in the ack cycle and then held in rdata_q.
    assign hs_rdata  = (hs_ack_q && ack_rd_q) ? ram_rdata : rdata_q;
    assign hs_ack    = hs_ack_q;
    assign hs_grant  = hs_grant_q;
    assign hs_abort  = hs_abort_q;
    assign pause_req = pause_req_q;

    assign w_cpu_we_block = (state_q == ST_SETTLE) || (state_q == ST_GRANT) ||
                            (state_q == ST_RELEASE);

    hs_ram_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .sel_hs_i       (hs_grant_q),
        .cpu_we_block_i (w_cpu_we_block),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_we_i       (cpu_we),
        .hs_addr_i      (hs_addr),
        .hs_wdata_i     (hs_wdata),
        .hs_we_i        (w_hs_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_we_o       (ram_we)
    );

endmodule

`default_nettype wire

// File: tb/tb_hs_ram_arbiter.sv
// ============================================================================
// Module   : tb_hs_ram_arbiter
// Brief    : Directed scoreboard bench for hs_ram_arbiter with a 1-cycle RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vblank = 1'b0;
    logic          hs_req = 1'b0;
    logic [AW-1:0] hs_addr = '0;
    logic [DW-1:0] hs_wdata = '0;
    logic          hs_we = 1'b0;
    logic          hs_strobe = 1'b0;
    logic [DW-1:0] hs_rdata;
    logic          hs_ack;
    logic          hs_grant;
    logic          hs_abort;
    logic          pause_req;
    logic          cpu_paused = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    logic          mem_init = 1'b1;
    logic [DW-1:0] mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    hs_ram_arbiter #(
        .AW(AW), .DW(DW), .SETTLE(4), .TIMEOUT(1023), .VBL_SYNC(1)
    ) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .hs_req(hs_req),
        .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
        .hs_strobe(hs_strobe), .hs_rdata(hs_rdata), .hs_ack(hs_ack),
        .hs_grant(hs_grant), .hs_abort(hs_abort), .pause_req(pause_req),
        .cpu_paused(cpu_paused), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // Synchronous RAM; power-up contents are addr[7:0] ^ 0x3C.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'(i) ^ 8'h3C;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rdata);
        hs_strobe = 1'b1;
        hs_we     = we;
        hs_addr   = a;
        hs_wdata  = d;
        exp_q.push_back(exp_rdata);
    endtask

    always @(negedge clk) begin
        if (hs_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                chk("ack_rdata", 32'(hs_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int abort_cnt;
        int abort_k;
        logic grant_seen;
        logic pause_after;

        cpu_addr = 11'h055;
        repeat (3) tick();
        mem_init = 1'b0;
        tick();
        #2;
        chk("rst_pause_req", 32'(pause_req), 32'd0);
        chk("rst_grant", 32'(hs_grant), 32'd0);
        chk("rst_ack", 32'(hs_ack), 32'd0);
        chk("rst_abort", 32'(hs_abort), 32'd0);
        chk("rst_rdata", 32'(hs_rdata), 32'd0);
        chk("rst_mux_cpu", 32'(ram_addr), 32'h055);
        reset = 1'b0;
        cpu_we = 1'b1; cpu_wdata = 8'h11;
        #1;
        chk("idle_cpu_we_pass", 32'(ram_we), 32'd1);
        chk("idle_cpu_wdata", 32'(ram_wdata), 32'h11);
        tick();
        cpu_we = 1'b0;

        // Vblank-synchronised session: vblank high in "cycle 100".
        hs_req = 1'b1;
        repeat (3) tick();
        #2 chk("wait_vbl_no_pause", 32'(pause_req), 32'd0);
        tick(); vblank = 1'b1;
        tick(); #2 chk("pause_at_101", 32'(pause_req), 32'd1);
        tick();
        tick(); cpu_paused = 1'b1;
        tick();
        cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'hEE;
        #2 chk("settle_cpu_we_gated", 32'(ram_we), 32'd0);
        repeat (3) tick();
        #2 chk("no_grant_at_107", 32'(hs_grant), 32'd0);
        tick(); #2 chk("grant_at_108", 32'(hs_grant), 32'd1);

        // Write 0x5A to 0x123 then read it back on consecutive strobes.
        strobe(1'b1, 11'h123, 8'h5A, 8'h00);
        #1;
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h123);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'h5A);
        tick();
        strobe(1'b0, 11'h123, 8'h00, 8'h5A);
        #1;
        chk("ack1_cycle", 32'(hs_ack), 32'd1);
        chk("rd_no_we", 32'(ram_we), 32'd0);
        tick();
        strobe(1'b0, 11'h200, 8'h00, 8'h3C);
        #1 chk("ack2_back_to_back", 32'(hs_ack), 32'd1);
        tick(); hs_strobe = 1'b0;
        tick();
        #2 chk("rdata_hold", 32'(hs_rdata), 32'h3C);
        chk("no_ack_idle_bus", 32'(hs_ack), 32'd0);

        // Release with a simultaneous strobe.
        strobe(1'b0, 11'h123, 8'h00, 8'h5A);
        tick();
        hs_req = 1'b0; hs_strobe = 1'b1; hs_we = 1'b1;
        hs_addr = 11'h300; hs_wdata = 8'h99;
        cpu_addr = 11'h0AA;
        #1 chk("drop_strobe_no_we", 32'(ram_we), 32'd0);
        tick();
        hs_strobe = 1'b0; hs_we = 1'b0;
        #2;
        chk("release_pause_req", 32'(pause_req), 32'd1);
        chk("release_grant", 32'(hs_grant), 32'd0);
        chk("release_no_ack", 32'(hs_ack), 32'd0);
        chk("release_mux_cpu", 32'(ram_addr), 32'h0AA);
        chk("release_cpu_we_gated", 32'(ram_we), 32'd0);
        tick();
        #2;
        chk("idle_pause_dropped", 32'(pause_req), 32'd0);
        chk("idle_cpu_we_back", 32'(ram_we), 32'd1);
        chk("mem_dropped_write", 32'(mem[11'h300]), 32'h3C);
        chk("mem_cpu_write_blocked", 32'(mem[11'h123]), 32'h5A);
        cpu_we = 1'b0;
        vblank = 1'b0;

        // Request withdrawn while waiting for vblank.
        hs_req = 1'b1;
        tick(); tick();
        hs_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #2 chk("wvbl_abort_no_pause", 32'(pause_req), 32'd0);
        end

        // Second session, re-requested during RELEASE (cpu_paused still high).
        hs_req = 1'b1;
        tick(); vblank = 1'b1;
        tick(); tick();
        repeat (4) tick();
        #2 chk("grant_session2", 32'(hs_grant), 32'd1);
        hs_req = 1'b0;
        tick();
        #2 chk("release2_pause_req", 32'(pause_req), 32'd1);
        hs_req = 1'b1; vblank = 1'b0;
        tick();
        vblank = 1'b1;
        #2 chk("idle_after_release", 32'(pause_req), 32'd0);
        tick(); #2 chk("no_skip_idle", 32'(pause_req), 32'd0);
        tick(); #2 chk("no_skip_idle2", 32'(pause_req), 32'd0);
        vblank = 1'b0;
        tick(); vblank = 1'b1;
        tick(); #2 chk("wait_vbl_after_idle", 32'(pause_req), 32'd1);

        // Reset in the middle of a granted session with strobes running.
        repeat (5) tick();
        #2 chk("grant_session3", 32'(hs_grant), 32'd1);
        strobe(1'b0, 11'h123, 8'h00, 8'h5A);
        tick();
        hs_strobe = 1'b1; hs_addr = 11'h200; reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("midrst_pause_req", 32'(pause_req), 32'd0);
        chk("midrst_grant", 32'(hs_grant), 32'd0);
        chk("midrst_ack", 32'(hs_ack), 32'd0);
        chk("midrst_mux_cpu", 32'(ram_addr), 32'h0AA);
        chk("midrst_rdata", 32'(hs_rdata), 32'd0);
        tick();
        #2 chk("strobe_ignored_ungranted", 32'(hs_ack), 32'd0);
        hs_strobe = 1'b0; hs_req = 1'b0;
        cpu_paused = 1'b0; vblank = 1'b0;
        tick(); tick();

        // Pause timeout: cpu_paused never rises.
        hs_req = 1'b1;
        tick(); vblank = 1'b1;
        tick(); #2 chk("to_pause_entry", 32'(pause_req), 32'd1);
        abort_cnt = 0; abort_k = -1; grant_seen = 1'b0; pause_after = 1'b1;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            #2;
            if (hs_abort) begin
                abort_cnt++;
                abort_k = k;
            end
            if (k == abort_k + 1) pause_after = pause_req;
            grant_seen = grant_seen | hs_grant;
        end
        chk("abort_count", 32'(abort_cnt), 32'd1);
        chk("abort_latency", 32'(abort_k), 32'd1023);
        chk("abort_pause_dropped", 32'(pause_after), 32'd0);
        chk("abort_no_grant", 32'(grant_seen), 32'd0);
        hs_req = 1'b0;
        tick(); tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
